// File: rtl/uart_rx.sv
// UART receiver: oversampled serial input, 8 data bits LSB first, optional
// parity, one stop bit. Bit values are taken by 3-sample majority vote around
// the bit centre. Results are reported by one-cycle pulses after the stop bit.
//
// Handshake: there is no back-pressure. data_valid is a single-cycle strobe
// qualifying P_DATA; the consumer must capture P_DATA in that cycle or rely on
// P_DATA holding until the next data_valid. par_err/stp_err are strobes in the
// same slot that data_valid would have occupied.
module uart_rx (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic [5:0] Prescale,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    output logic [7:0] P_DATA,
    output logic       data_valid,
    output logic       par_err,
    output logic       stp_err,
    output logic       rx_busy,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t     state;
    logic       rx_meta;
    logic       rx_s;
    logic [5:0] edge_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic [2:0] samples;
    logic [5:0] p_lat;
    logic       par_en_lat;
    logic       par_typ_lat;
    logic       par_fail;

    logic [5:0] prescale_norm;
    logic [5:0] half;
    logic [5:0] last_edge;
    logic       bit_end;
    logic       bit_val;
    logic       exp_par;

    // Map the raw Prescale input onto a supported ratio; anything else runs at 16.
    always_comb begin
        prescale_norm = 6'd16;
        case (Prescale)
            6'd8:    prescale_norm = 6'd8;
            6'd16:   prescale_norm = 6'd16;
            6'd32:   prescale_norm = 6'd32;
            default: prescale_norm = 6'd16;
        endcase
    end

    assign half      = p_lat >> 1;
    assign last_edge = p_lat - 6'd1;
    assign bit_end   = (edge_cnt == last_edge);
    // Majority of the three centre samples; all three are captured well before
    // the last tick of the bit, even at the smallest ratio.
    assign bit_val   = (samples[0] & samples[1]) | (samples[1] & samples[2]) |
                       (samples[0] & samples[2]);
    assign exp_par   = par_typ_lat ? ~^shift_reg : ^shift_reg;

    assign rx_busy   = (state != IDLE);
    assign state_dbg = state;

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX_IN;
            rx_s    <= rx_meta;
        end
    end

    // Receive FSM: bit timing, sampling, shifting, parity/stop evaluation and
    // the registered result strobes.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            edge_cnt    <= 6'd0;
            bit_cnt     <= 3'd0;
            shift_reg   <= 8'h00;
            samples     <= 3'b000;
            p_lat       <= 6'd16;
            par_en_lat  <= 1'b0;
            par_typ_lat <= 1'b0;
            par_fail    <= 1'b0;
            P_DATA      <= 8'h00;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;

            if (state != IDLE) begin
                if (edge_cnt == half - 6'd2) samples[0] <= rx_s;
                if (edge_cnt == half - 6'd1) samples[1] <= rx_s;
                if (edge_cnt == half)        samples[2] <= rx_s;
                edge_cnt <= bit_end ? 6'd0 : edge_cnt + 6'd1;
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state       <= START;
                        edge_cnt    <= 6'd0;
                        bit_cnt     <= 3'd0;
                        par_fail    <= 1'b0;
                        p_lat       <= prescale_norm;
                        par_en_lat  <= PAR_EN;
                        par_typ_lat <= PAR_TYP;
                    end
                end
                START: begin
                    if (bit_end) begin
                        // A start bit that reads high was noise: drop silently.
                        state <= bit_val ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_reg <= {bit_val, shift_reg[7:1]};
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= 3'd0;
                            state   <= par_en_lat ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        par_fail <= (bit_val != exp_par);
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state <= IDLE;
                        if (!par_fail && bit_val) begin
                            P_DATA     <= shift_reg;
                            data_valid <= 1'b1;
                        end else begin
                            par_err <= par_fail;
                            stp_err <= ~bit_val;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameters: none; all configuration is through ports.
REQ-002 CLK  in  1  oversampling clock; one tick = 1/Prescale of a bit period.
REQ-003 RST  in  1  reset; asynchronous, active-low.
REQ-004 RX_IN  in  1  serial line; idles high.
REQ-005 Prescale  in  6  oversampling ratio; legal values 8, 16, 32.
REQ-006 PAR_EN  in  1  1 = frame carries a parity bit.
REQ-007 PAR_TYP  in  1  0 = even parity (bit = ^data); 1 = odd parity (bit = ~^data).
REQ-008 P_DATA  out  8  last correctly received byte.
REQ-009 data_valid  out  1  one-cycle pulse when P_DATA is updated.
REQ-010 par_err  out  1  one-cycle pulse on parity mismatch.
REQ-011 stp_err  out  1  one-cycle pulse on a stop bit sampled as 0.
REQ-012 rx_busy  out  1  high whenever the state is not IDLE.

Function
REQ-013 Frame format: start bit (0), 8 data bits LSB first, optional parity bit, one stop bit (1).
REQ-014 RX_IN passes through a 2-flop synchronizer that resets to 1; all timing below refers to the synchronized signal rx_s.
REQ-015 States are IDLE, START, DATA, PARITY and STOP; edge_cnt counts 0..Prescale-1 within each bit; bit_cnt counts data bits 0..7.
REQ-016 IDLE: rx_s == 0 -> START with edge_cnt = 0; Prescale, PAR_EN and PAR_TYP are latched at this transition and held constant for the rest of the frame.
REQ-017 A latched Prescale outside {8, 16, 32} behaves as 16.
REQ-018 Bit value = majority of rx_s samples taken at edge_cnt = P/2-2, P/2-1 and P/2, where P is the latched Prescale.
REQ-019 Each state ends at edge_cnt == P-1; edge_cnt then wraps to 0.
REQ-020 START end: sampled bit 0 -> DATA; sampled bit 1 -> IDLE (false start, no output pulse).
REQ-021 DATA: each sampled bit is shifted into the internal shift register LSB first; at the end of bit_cnt == 7 -> PARITY if PAR_EN, else STOP.
REQ-022 PARITY: compare the sampled bit with the expected parity of the shift register; mismatch sets an internal parity-fail flag.
REQ-023 STOP end: the state always returns to IDLE, and on the following cycle exactly one of these applies:
 - parity OK and stop bit 1 -> P_DATA <= shift register, data_valid = 1;
 - otherwise -> par_err = 1 if parity failed and stp_err = 1 if stop bit was 0 (both may pulse together); P_DATA is unchanged.
REQ-024 Latency: outputs pulse exactly 1 cycle after the last tick of the stop bit.
REQ-025 P_DATA holds its value between frames and changes only together with data_valid.
REQ-026 Back-to-back frames: a start bit arriving right after the stop bit is detected from IDLE; the 1-tick alignment loss is tolerated.
REQ-027 Configuration-input changes mid-frame have no effect until the next start detection.

Reset
REQ-028 RST low, at any time and in any state, asynchronously forces: state IDLE, counters 0, shift register 0, P_DATA = 0x00, data_valid = par_err = stp_err = rx_busy = 0, synchronizer flops = 1.
REQ-029 After RST is released, the first falling edge on rx_s starts a new frame; a partial frame interrupted by reset produces no output pulse.

Verification
REQ-030 Prescale=16, PAR_EN=0, send 0xA5 -> exactly one data_valid pulse, P_DATA=0xA5, no error pulses, rx_busy low afterwards.
REQ-031 Prescale=8, PAR_EN=1, PAR_TYP=0: send 0x3C with parity bit 0 -> data_valid, P_DATA=0x3C; resend with parity bit 1 -> par_err pulse only, P_DATA stays 0x3C.
REQ-032 Prescale=32, PAR_EN=1, PAR_TYP=1: send 0x01 with parity bit 0 -> data_valid, P_DATA=0x01; send 0x02 with stop bit 0 and parity bit 1 -> stp_err and par_err pulse in the same cycle, P_DATA stays 0x01.
REQ-033 Prescale=16: RX_IN low for 3 ticks then high -> returns to IDLE, no pulses; a single-tick glitch inside a data bit is rejected by the majority vote, so 0x55 is received intact.
REQ-034 Back-to-back 0x11 then 0x22 with zero idle gap -> two data_valid pulses, P_DATA=0x11 then 0x22.
REQ-035 RST pulsed during data bit 4 -> all outputs 0 immediately, no pulse for the aborted frame; the next frame 0x5A is received correctly.
